// File: rtl/wb_uart_tx.sv
// Wishbone slave UART transmitter (8N1) with a byte FIFO.
// Registers: 0 TXDATA (push), 1 STATUS (flags/count, W1C overflow), 2 DIV, 3 reserved.
module wb_uart_tx #(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus-side registers
  logic          ack_q;
  logic [31:0]   dat_q;
  logic [15:0]   div_q;
  logic          ovf_q;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Transmitter state
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          irq_q;
  logic          pop;

  // Decode of the current bus request
  logic          accept;
  logic [1:0]    reg_sel;
  logic          push_req, push_ok, full, empty, busy, ovf_clr;
  logic [7:0]    count8;
  logic [31:0]   rdata;

  // Address bits outside [3:2], byte selects and upper data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16]};

  assign accept   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign reg_sel  = wb_adr_i[3:2];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign push_req = accept & wb_we_i & (reg_sel == 2'd0);
  // Fullness is judged on the registered count, so a same-cycle pop cannot rescue a push.
  assign push_ok  = push_req & ~full;
  assign ovf_clr  = accept & wb_we_i & (reg_sel == 2'd1) & wb_dat_i[3];
  assign count8   = 8'(count_q);

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

  // Read-data mux for the addressed register
  always_comb begin
    rdata = 32'h0;
    case (reg_sel)
      2'd1:    rdata = {16'h0, count8, 4'h0, ovf_q, busy, empty, full};
      2'd2:    rdata = {16'h0, div_q};
      default: rdata = 32'h0;
    endcase
  end

  // Single-cycle ack, read-data capture, DIV register and sticky overflow flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      ack_q <= accept;
      dat_q <= (accept & ~wb_we_i) ? rdata : 32'h0;
      if (accept && wb_we_i && reg_sel == 2'd2)
        div_q <= wb_dat_i[15:0];
      // Set takes priority over a clear in the same cycle.
      if (push_req && full)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  // FIFO data array; contents need no reset because count gates every read
  always_ff @(posedge clk_i) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= wb_dat_i[7:0];
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmit FSM next state; the bit timer reloads from DIV at every bit start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = div_q;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == 16'h0) begin
          cnt_d   = div_q;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'h0) begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = div_q;
          if (bit_q == 3'd7)
            state_d = S_STOP;
          else
            bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 16'h0)
          state_d = S_IDLE;
        else
          cnt_d = cnt_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the next state so tx_o comes straight from a flop
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Transmit FSM registers, line driver and interrupt flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'h0;
      bit_q   <= 3'd0;
      shift_q <= 8'h0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= empty & (state_q == S_IDLE);
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: register access, 8N1 framing, FIFO overflow, ack shape, reset.
module tb_wb_uart_tx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_adr_i = '0;
  logic [1:0]  wb_sel_i = 2'b11;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic        tx_o;
  logic        irq_o;

  int n_chk = 0;
  int n_bad = 0;
  int n_xfers = 0;
  int n_acks = 0;
  int n_ack_dbl = 0;
  int cyc_cnt = 0;
  int bit_clks = 434;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  wb_uart_tx #(.DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .tx_o(tx_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Ack shape monitor: counts pulses and flags any ack held two cycles.
  logic ack_prev = 1'b0;
  always @(negedge clk_i) begin
    if (wb_ack_o) n_acks++;
    if (wb_ack_o && ack_prev) n_ack_dbl++;
    ack_prev <= wb_ack_o;
  end

  task automatic wait_cyc(input int n, inout logic ok);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (!rst_i) ok = 1'b0;
    end
  endtask

  // Serial decoder: samples mid-bit, logs byte and start cycle; aborts on reset.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i && tx_o === 1'b0) begin
        int         b;
        int         t0;
        logic       ok;
        logic [7:0] d;
        logic       stp;
        b  = bit_clks;
        t0 = cyc_cnt;
        ok = 1'b1;
        d  = 8'h0;
        wait_cyc(b / 2, ok);
        for (int k = 0; k < 8 && ok; k++) begin
          wait_cyc(b, ok);
          d[k] = tx_o;
        end
        if (ok) wait_cyc(b, ok);
        stp = tx_o;
        if (ok) begin
          chk("stop_bit", 32'(stp), 32'h1);
          rx_q.push_back(d);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rdat);
    logic got;
    got = 1'b0;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk_i);
      got = wb_ack_o;
    end
    if (!got) chk("ack_timeout", 32'h0, 32'h1);
    rdat = wb_dat_o;
    n_xfers++;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    $display("wb %s adr=0x%0h wdat=0x%08h rdat=0x%08h", we ? "wr" : "rd", adr, dat, rdat);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, dat, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
    wb_xfer(1'b0, adr, 32'h0, rdat);
  endtask

  initial begin
    logic [31:0] r;
    logic [9:0]  a5_seq;
    logic [7:0]  exp_b;
    int          nfr;

    // 1. Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_tx", 32'(tx_o), 32'h1);
    chk("rst_irq", 32'(irq_o), 32'h1);
    chk("rst_ack", 32'(wb_ack_o), 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    rst_i = 1'b1;
    @(negedge clk_i);
    wb_read(32'h4, r);  chk("status_rst", r, 32'h0000_0002);
    wb_read(32'h8, r);  chk("div_rst", r, 32'h0000_01B1);
    @(negedge clk_i);
    chk("dat_idle", wb_dat_o, 32'h0);

    // 2. Single frame 0xA5 at DIV=3: start, LSB-first data, stop, 4 clocks each
    bit_clks = 4;
    wb_write(32'h8, 32'd3);
    wb_write(32'h0, 32'hA5);
    a5_seq = 10'b1101001010;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      chk($sformatf("a5_bit%0d", i), 32'(tx_o), 32'(a5_seq[i / 4]));
      if (i == 20) chk("irq_busy", 32'(irq_o), 32'h0);
    end
    repeat (3) @(negedge clk_i);
    chk("irq_after", 32'(irq_o), 32'h1);
    chk("a5_decoded", 32'(rx_q.size()), 32'h1);
    if (rx_q.size() > 0) chk("a5_byte", 32'(rx_q[0]), 32'hA5);
    rx_q.delete();
    rx_t.delete();

    // 3. Three back-to-back bytes: one popped at once, two left queued
    wb_write(32'h0, 32'h41);
    wb_write(32'h0, 32'h42);
    wb_write(32'h0, 32'h43);
    wb_read(32'h4, r);  chk("status_q2", r, 32'h0000_0204);
    for (int i = 0; i < 300 && rx_q.size() < 3; i++) @(negedge clk_i);
    chk("three_frames", 32'(rx_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++)
      chk($sformatf("byte%0d", i), 32'(rx_q[i]), 32'h41 + 32'(i));
    if (rx_t.size() >= 3) begin
      chk("gap01", 32'(rx_t[1] - rx_t[0]), 32'd41);
      chk("gap12", 32'(rx_t[2] - rx_t[1]), 32'd41);
    end
    repeat (10) @(negedge clk_i);
    wb_read(32'h4, r);  chk("status_idle3", r, 32'h0000_0002);
    rx_q.delete();
    rx_t.delete();

    // 4. Overflow: 10 rapid writes, 1 popped, 8 stored, 10th dropped
    bit_clks = 101;
    wb_write(32'h8, 32'd100);
    for (int i = 0; i < 10; i++) wb_write(32'h0, 32'h10 + 32'(i));
    wb_read(32'h4, r);  chk("status_ovf", r, 32'h0000_080D);
    wb_write(32'h4, 32'h8);
    wb_read(32'h4, r);  chk("status_ovfclr", r, 32'h0000_0805);
    for (int i = 0; i < 12000 && rx_q.size() < 9; i++) @(negedge clk_i);
    repeat (1200) @(negedge clk_i);
    chk("nine_frames", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
      exp_b = 8'h10 + 8'(i);
      chk($sformatf("ovf_byte%0d", i), 32'(rx_q[i]), 32'(exp_b));
    end
    wb_read(32'h4, r);  chk("status_idle4", r, 32'h0000_0002);

    // 5. Reserved address, TXDATA read, write to reserved leaves DIV intact
    wb_read(32'hC, r);  chk("rsvd_rd", r, 32'h0);
    wb_write(32'hC, 32'hFFFF_FFFF);
    wb_read(32'h0, r);  chk("txdata_rd", r, 32'h0);
    wb_read(32'h8, r);  chk("div_kept", r, 32'd100);
    @(negedge clk_i);
    chk("dat_after_ack", wb_dat_o, 32'h0);
    chk("ack_after", 32'(wb_ack_o), 32'h0);
    chk("status_rsvd", 32'(rx_q.size()), 32'd9);

    // 6. Reset asserted during data bit 3 of a 0xF0 frame with a second byte queued
    bit_clks = 4;
    wb_write(32'h8, 32'd3);
    wb_write(32'h0, 32'hF0);
    wb_write(32'h0, 32'h77);
    nfr = rx_q.size();
    repeat (16) @(negedge clk_i);
    chk("pre_rst_bit3", 32'(tx_o), 32'h0);
    #1 rst_i = 1'b0;
    #1;
    chk("rst_tx_async", 32'(tx_o), 32'h1);
    chk("rst_irq_async", 32'(irq_o), 32'h1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    wb_read(32'h4, r);  chk("status_post_rst", r, 32'h0000_0002);
    repeat (200) @(negedge clk_i);
    chk("no_frame_post_rst", 32'(rx_q.size()), 32'(nfr));
    chk("tx_idle_post_rst", 32'(tx_o), 32'h1);

    // Ack accounting over the whole run
    chk("ack_count", 32'(n_acks), 32'(n_xfers));
    chk("ack_double", 32'(n_ack_dbl), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
